// File: rtl/collide_sweep_ctrl.sv
// collide_sweep_ctrl: walks every lattice node through read, collide and in-place write-back, one node at a time.
module collide_sweep_ctrl #(
   parameter int NX         = 4,
   parameter int NY         = 4,
   parameter int ADDR_W     = 12,
   parameter int RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [15:0]       omega_in,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] node_idx,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [143:0]      rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [143:0]      wr_data,
   input  logic              wr_ready,
   output logic [15:0]       col_omega,
   output logic [143:0]      col_f,
   input  logic [143:0]      col_f_new,
   input  logic              col_busy
);
   localparam int CW = $clog2(RD_LATENCY + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NX * NY - 1);

   typedef enum logic [2:0] {IDLE, READ, WAIT, COLLIDE, WRITE, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic abort_q;

   assign busy    = state != IDLE;
   assign done    = state == DONE;
   assign rd_en   = state == READ;
   assign wr_en   = state == WRITE;
   assign rd_addr = node_idx;
   assign wr_addr = node_idx;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   // an abort seen during WRITE only takes effect once the pending write is accepted
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (start && !abort) ? READ : IDLE;
         READ:    state_nx = abort ? IDLE : WAIT;
         WAIT:    state_nx = abort ? IDLE : (cnt == CW'(1) ? COLLIDE : WAIT);
         COLLIDE: state_nx = abort ? IDLE : (col_busy ? COLLIDE : WRITE);
         WRITE:   state_nx = !wr_ready ? WRITE : (abort || abort_q) ? IDLE : (node_idx == LAST ? DONE : READ);
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         node_idx  <= '0;
         cnt       <= '0;
         abort_q   <= 1'b0;
         col_omega <= '0;
         col_f     <= '0;
         wr_data   <= '0;
      end else begin
         if (state == IDLE) abort_q <= 1'b0;
         else if (state == WRITE && abort) abort_q <= 1'b1;
         if (state == IDLE && start && !abort) begin
            col_omega <= omega_in;
            node_idx  <= '0;
         end
         if (state == READ) cnt <= CW'(RD_LATENCY);
         if (state == WAIT) cnt <= cnt - 1'b1;
         if (state == WAIT && cnt == CW'(1)) col_f <= rd_data;
         if (state == COLLIDE && !col_busy) wr_data <= col_f_new;
         if (state == WRITE && wr_ready && node_idx != LAST) node_idx <= node_idx + 1'b1;
      end
endmodule

// File: tb/tb_collide_sweep_ctrl.sv
// tb_collide_sweep_ctrl: randomized sweeps with stalls and aborts against a cycle-count and memory-content model.
module tb_collide_sweep_ctrl;
   localparam int NX = 2, NY = 2, AW = 12, L = 2, N = NX * NY;

   logic clk = 0, rst = 1, start = 0, abort = 0, wr_ready = 1, col_busy = 0;
   logic [15:0] omega_in = 0, col_omega;
   logic busy, done, rd_en, wr_en;
   logic [AW-1:0] node_idx, rd_addr, wr_addr;
   logic [143:0] rd_data = '0, wr_data, col_f, col_f_new;

   collide_sweep_ctrl #(.NX(NX), .NY(NY), .ADDR_W(AW), .RD_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .omega_in(omega_in),
      .busy(busy), .done(done), .node_idx(node_idx), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .col_omega(col_omega), .col_f(col_f),
      .col_f_new(col_f_new), .col_busy(col_busy)
   );

   always #5 clk = ~clk;

   typedef struct {int c; int a; logic [143:0] d;} ev_t;
   ev_t rq[$], wq[$];
   int dq[$], pdue[$], pa[$];
   logic [143:0] mem[N], mem0[N], pdata;
   int cb[N], ws[N], wcnt[N];
   int cyc = 0, n_cmp = 0, n_bad = 0, nbusy = 0, s = 0, r_last = -100, ra = 0, d = 0, c = 0, paddr = 0;
   logic [15:0] exp_om = 0;
   bit rst_evt = 0, pstall = 0, found = 0;

   function automatic logic [143:0] collide(input logic [143:0] f);
      logic [143:0] o;
      for (int k = 0; k < 9; k++) o[16*k +: 16] = f[16*k +: 16] + 16'(k + 1);
      return o;
   endfunction

   function automatic logic [143:0] rnd144();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[143:0];
   endfunction

   assign col_f_new = collide(col_f);

   task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // memory, collider and write-port responder
   initial forever begin
      @(posedge clk);
      #2;
      if (rd_en) begin
         r_last = cyc;
         ra = int'(rd_addr) % N;
         pdue.push_back(cyc + L);
         pa.push_back(ra);
      end
      while (pdue.size() > 0 && pdue[0] < cyc) begin
         void'(pdue.pop_front());
         void'(pa.pop_front());
      end
      rd_data = rnd144();
      if (pdue.size() > 0 && pdue[0] == cyc) rd_data = mem[pa[0]];
      d = cyc - r_last;
      col_busy = (d >= L + 1 && d <= L + cb[ra]) ? 1'b1 : (d == L + cb[ra] + 1) ? 1'b0 : 1'($urandom % 2);
      wr_ready = wr_en ? 1'b1 : 1'($urandom % 2);
      if (wr_en && wcnt[int'(wr_addr) % N] < ws[int'(wr_addr) % N]) begin
         wr_ready = 1'b0;
         wcnt[int'(wr_addr) % N]++;
      end
   end

   initial forever begin
      @(negedge clk);
      check("rd_wr_excl", 144'(rd_en && wr_en), 144'(0));
      if (rd_en) rq.push_back('{cyc, int'(rd_addr), 144'(0)});
      if (wr_en && wr_ready) begin
         wq.push_back('{cyc, int'(wr_addr), wr_data});
         mem[int'(wr_addr) % N] = wr_data;
      end
      if (done) dq.push_back(cyc);
      if (busy) begin
         nbusy++;
         check("col_omega", 144'(col_omega), 144'(exp_om));
      end
      if (pstall && !rst_evt) begin
         check("wr_hold_en", 144'(wr_en), 144'(1));
         check("wr_hold_addr", 144'(wr_addr), 144'(paddr));
         check("wr_hold_data", wr_data, pdata);
      end
      rst_evt = 0;
      pstall = wr_en && !wr_ready;
      paddr = int'(wr_addr);
      pdata = wr_data;
   end

   task automatic kick(input logic [15:0] om);
      for (int i = 0; i < N; i++) wcnt[i] = 0;
      mem0 = mem;
      rq.delete(); wq.delete(); dq.delete();
      nbusy = 0;
      @(posedge clk); #1;
      omega_in = om; start = 1; exp_om = om; s = cyc;
      @(posedge clk); #1;
      start = 0; omega_in = ~om;
   endtask

   task automatic sweep(input logic [15:0] om);
      int r, w;
      kick(om);
      repeat (6) @(posedge clk);
      #1; start = 1;
      @(posedge clk); #1; start = 0;
      r = s + 1;
      for (int n = 0; n < N; n++) begin
         w = r + L + 2 + cb[n] + ws[n];
         r = w + 1;
      end
      while (cyc < r + 3) @(posedge clk);
      check("n_reads", 144'(rq.size()), 144'(N));
      check("n_writes", 144'(wq.size()), 144'(N));
      check("n_done", 144'(dq.size()), 144'(1));
      r = s + 1;
      for (int n = 0; n < N; n++) begin
         w = r + L + 2 + cb[n] + ws[n];
         if (n < rq.size()) begin
            check("rd_cyc", 144'(rq[n].c), 144'(r));
            check("rd_addr", 144'(rq[n].a), 144'(n));
         end
         if (n < wq.size()) begin
            check("wr_cyc", 144'(wq[n].c), 144'(w));
            check("wr_addr", 144'(wq[n].a), 144'(n));
            check("wr_data", wq[n].d, collide(mem0[n]));
         end
         r = w + 1;
      end
      if (dq.size() > 0) check("done_cyc", 144'(dq[0]), 144'(r));
      check("busy_cycles", 144'(nbusy), 144'(r - s));
   endtask

   task automatic clear_stalls();
      for (int i = 0; i < N; i++) begin
         cb[i] = 0;
         ws[i] = 0;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 144'(busy), 144'(0));
      check({tag, "_done"}, 144'(done), 144'(0));
      check({tag, "_rd_en"}, 144'(rd_en), 144'(0));
      check({tag, "_wr_en"}, 144'(wr_en), 144'(0));
      check({tag, "_node_idx"}, 144'(node_idx), 144'(0));
      check({tag, "_rd_addr"}, 144'(rd_addr), 144'(0));
      check({tag, "_wr_addr"}, 144'(wr_addr), 144'(0));
      check({tag, "_wr_data"}, wr_data, 144'(0));
      check({tag, "_col_f"}, col_f, 144'(0));
      check({tag, "_col_omega"}, 144'(col_omega), 144'(0));
   endtask

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog cyc=%0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) mem[i] = rnd144();
      clear_stalls();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 0;

      sweep(16'h2000);
      cb[0] = 2; ws[1] = 3;
      sweep(16'h1A2B);
      repeat (6) begin
         for (int i = 0; i < N; i++) begin
            cb[i] = $urandom_range(0, 3);
            ws[i] = $urandom_range(0, 3);
            mem[i] = rnd144();
         end
         sweep(16'($urandom));
      end
      clear_stalls();

      kick(16'h0C00);
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(posedge clk); #1;
         found = rd_en && rd_addr == 2;
      end
      check("abort_wait_seen", 144'(found), 144'(1));
      @(posedge clk); #1; abort = 1;
      @(posedge clk); #1; abort = 0;
      check("abort_wait_busy", 144'(busy), 144'(0));
      check("abort_wait_rd_en", 144'(rd_en), 144'(0));
      repeat (10) @(posedge clk);
      #1;
      check("abort_wait_writes", 144'(wq.size()), 144'(2));
      check("abort_wait_done", 144'(dq.size()), 144'(0));
      check("abort_wait_mem2", mem[2], mem0[2]);

      ws[1] = 4;
      kick(16'h0D00);
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(posedge clk); #1;
         if (wr_en && wr_addr == 1) begin
            found = 1; abort = 1; c = cyc;
         end
      end
      check("abort_wr_seen", 144'(found), 144'(1));
      @(posedge clk); #1; abort = 0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_wr_busy", 144'(busy), 144'(0));
      check("abort_wr_wr_en", 144'(wr_en), 144'(0));
      repeat (8) @(posedge clk);
      #1;
      check("abort_wr_writes", 144'(wq.size()), 144'(2));
      check("abort_wr_reads", 144'(rq.size()), 144'(2));
      check("abort_wr_done", 144'(dq.size()), 144'(0));
      if (wq.size() >= 2) begin
         check("abort_wr_cyc", 144'(wq[1].c), 144'(c + 4));
         check("abort_wr_addr", 144'(wq[1].a), 144'(1));
         check("abort_wr_data", wq[1].d, collide(mem0[1]));
      end
      ws[1] = 0;

      @(posedge clk); #1; start = 1; abort = 1;
      @(posedge clk); #1; start = 0; abort = 0;
      check("abort_start_busy", 144'(busy), 144'(0));
      check("abort_start_rd_en", 144'(rd_en), 144'(0));
      @(posedge clk); #1;
      check("abort_start_busy2", 144'(busy), 144'(0));

      ws[0] = 5;
      kick(16'h0E00);
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(posedge clk); #1;
         found = wr_en && wr_addr == 0;
      end
      check("rst_wr_seen", 144'(found), 144'(1));
      #2; rst_evt = 1; rst = 1;
      #1;
      check_zero("async_rst");
      rst = 0;
      check("rst_mem0", mem[0], mem0[0]);
      ws[0] = 0;
      sweep(16'h2468);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/collide_sweep_ctrl.md
Name: collide_sweep_ctrl

Overview:
- Sequences the combinational D2Q9 collider across the whole NX×NY lattice.
- Per node: reads the packed 9-population word from lattice memory, presents it to the collider with a latched omega, captures the post-collision populations, and writes them back in place.
- Sits between the host/AXI control layer (start/done) and the lattice memory plus collider datapath.
- Non-pipelined: one node in flight.

Parameters:
- NX, 4, lattice width in nodes
- NY, 4, lattice height in nodes
- ADDR_W, 12, memory address width; must satisfy 2^ADDR_W ≥ NX*NY
- RD_LATENCY, 2, memory read latency in cycles; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one sweep; sampled only in IDLE
- abort  in  1  synchronous abandon of the current sweep
- omega_in  in  16  relaxation rate, Q3.13, latched on accepted start
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last node's write is accepted
- node_idx  out  ADDR_W  address of the node currently in flight
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  144  packed populations; valid exactly RD_LATENCY cycles after rd_en
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  144  packed post-collision populations
- wr_ready  in  1  memory accepts the write when wr_en && wr_ready
- col_omega  out  16  omega to the collider
- col_f  out  144  populations to the collider
- col_f_new  in  144  collider result
- col_busy  in  1  collider not yet valid; extends COLLIDE

Behaviour:
- Packing (all 144-bit buses): [15:0] null, [31:16] n, [47:32] ne, [63:48] e, [79:64] se, [95:80] s, [111:96] sw, [127:112] w, [143:128] nw. Each lane is signed Q3.13.
- The controller does no arithmetic on populations; it passes data bit-exact.
- Reset (async, rst=1): state IDLE. busy, done, rd_en, wr_en = 0. node_idx, rd_addr, wr_addr, wr_data, col_f, col_omega = 0.
- IDLE:
  - On start=1: latch omega_in into col_omega, set node_idx=0, busy=1, go to READ.
  - start while not in IDLE is ignored.
- READ (1 cycle): rd_en=1, rd_addr=node_idx. Go to WAIT with wait counter = RD_LATENCY.
- WAIT (RD_LATENCY cycles): decrement the counter each cycle. On the cycle the counter reaches 1, register rd_data into col_f and go to COLLIDE.
- COLLIDE:
  - col_f and col_omega are held stable.
  - If col_busy=0: register col_f_new into wr_data and go to WRITE.
  - If col_busy=1: stay in COLLIDE.
- WRITE:
  - wr_en=1, wr_addr=node_idx; wr_data is held stable until accepted.
  - On wr_en && wr_ready: if node_idx == NX*NY-1, go to DONE; otherwise increment node_idx and go to READ.
  - If wr_ready=0: hold all write outputs unchanged.
- DONE (1 cycle): done=1, busy=0 on exit, go to IDLE.
- Throughput with wr_ready=1 and col_busy=0: RD_LATENCY+3 cycles per node (5 at default). The first READ occurs the cycle after start is sampled.
- abort=1 in READ, WAIT or COLLIDE: go to IDLE next cycle. rd_en deasserts, no write is issued, done is not pulsed, busy=0.
- abort=1 in WRITE:
  - The pending write completes first (wr_en held until wr_ready).
  - The controller then goes to IDLE with no done pulse.
  - abort is remembered via a sticky flag cleared in IDLE.
- abort and start in the same IDLE cycle: abort wins, start is ignored.
- rd_en and wr_en are never high in the same cycle.
- omega_in changes after start do not affect the running sweep.
- Reset asserted mid-sweep: immediate return to reset values. Any in-flight write is dropped.

Test Plan:
- Basic sweep (NX=NY=2, RD_LATENCY=2, wr_ready=1, col_busy=0, memory preloaded with node index in every lane, collider model = lane+1): start at cycle 0.
  - Reads go to addresses 0,1,2,3 at cycles 1,6,11,16.
  - Writes go to the same addresses at cycles 5,10,15,20, each lane equal to addr+1.
  - done pulses at cycle 21; busy is high during cycles 1–21.
- Backpressure: hold wr_ready=0 for 3 cycles on node 1 → wr_en, wr_addr=1 and wr_data stay stable for 4 cycles. No read is issued until the write is accepted. done is delayed by exactly 3 cycles.
- col_busy stretch: col_busy=1 for 2 cycles on node 0 → COLLIDE lasts 3 cycles, write occurs 2 cycles later, data is correct.
- Omega latch: start with omega_in=16'h2000, change it to 16'h1000 mid-sweep → col_omega stays 16'h2000 for the whole sweep.
- Abort:
  - abort during WAIT on node 2 → idle next cycle, no write to address 2, no done pulse.
  - abort during a stalled WRITE → that write still completes once wr_ready=1, then idle, no done pulse.
- Async reset mid-WRITE (rst pulsed between clock edges) → all outputs 0 immediately. A fresh start afterwards runs a full sweep with the correct cycle counts.
